maglev_p_ctrl: RTL
==================

Name: maglev_p_ctrl

Overview:
Proportional position controller for the levitation loop. Consumes the 10-bit kp gain driven by the kp PIO output register, a setpoint and a Hall/ADC position sample. Computes a saturated coil duty cycle and drives the coil-driver gate through an internal PWM generator. Sits between the ADC sample interface and the coil driver pin.

Parameters:
ADC_W, 12, width of position sample and setpoint (unsigned)
KP_W, 10, width of kp gain (unsigned); matches the kp PIO output width
KP_FRAC, 4, fractional bits of kp (gain = kp / 2^KP_FRAC)
PWM_W, 10, duty resolution; PWM period = 2^PWM_W clk cycles
BIAS, 512, duty offset added to the P term (hover operating point)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  loop enable; 0 forces coil off
kp  in  KP_W  proportional gain (unsigned, static or slow-changing)
setpoint  in  ADC_W  target position (unsigned)
adc_data  in  ADC_W  position sample
adc_valid  in  1  one-cycle strobe, adc_data valid
duty  out  PWM_W  last computed duty
duty_valid  out  1  one-cycle strobe, duty updated
sat_hi  out  1  last result clipped high (sticky until next duty_valid)
sat_lo  out  1  last result clipped low (sticky until next duty_valid)
pwm_out  out  1  coil gate drive

Behaviour:
- Reset (async, reset_n=0): all pipeline registers 0; duty=0, duty_valid=0, sat_hi=0, sat_lo=0, pwm_out=0, PWM counter=0, active duty=0.
- 3-stage pipeline, fully pipelined: accepts adc_valid every cycle. Latency: adc_valid at cycle N -> duty_valid at N+3.
- S1 (on adc_valid & enable): err = {0,setpoint} - {0,adc_data}, signed ADC_W+1 bits. kp is sampled in the same cycle, so a kp change never mixes into an in-flight sample.
- S2: prod = err * signed({0,kp}), signed ADC_W+KP_W+2 bits, exact.
- S3: scaled = prod >>> KP_FRAC (arithmetic shift, rounds toward -inf). sum = scaled + BIAS, computed with one guard bit, no overflow.
  - sum < 0: duty=0, sat_lo=1.
  - sum > 2^PWM_W-1: duty=2^PWM_W-1, sat_hi=1.
  - otherwise: duty=sum[PWM_W-1:0], both sat flags 0.
  - duty_valid pulses 1 cycle.
- Valid bits travel with the data through each stage. adc_valid while enable=0 is ignored.
- enable falling: all stage valid bits cleared the same cycle; in-flight samples are discarded, no duty_valid. duty register forced to 0 on the next cycle. sat flags cleared.
- PWM sub-block:
  - free-running counter 0..2^PWM_W-1, wraps to 0.
  - active duty loaded from duty only when counter == 2^PWM_W-1, giving glitch-free, period-aligned updates.
  - pwm_out = (counter < active_duty) & enable, registered.
  - duty=0 gives constant low. duty=2^PWM_W-1 gives high for all but 1 cycle per period.
- enable=0: pwm_out low within 1 cycle regardless of counter phase.
- Reset mid-operation: immediate return to reset state. The first valid duty requires a fresh adc_valid.

Decomposition:
- Shared package maglev_pkg:
  - ADC_W, KP_W, PWM_W defaults
  - typedef err_t (signed ADC_W+1)
  - typedef prod_t
  - typedef duty_t
- One sub-module, maglev_pwm_gen: counter, period-aligned duty reload, pwm_out.
- Top level holds the pipeline and saturation logic.

Test Plan:
1. Zero error: setpoint=2048, adc=2048, kp=16, one adc_valid -> duty_valid exactly 3 cycles later, duty=512, sat_hi=sat_lo=0.
2. Positive error: setpoint=2100, adc=2048, kp=16 -> err=52, prod=832, scaled=52, duty=564. Next, kp=40 with the same sample -> scaled=130, duty=642.
3. Saturation: setpoint=4095, adc=0, kp=1023 -> duty=1023, sat_hi=1. setpoint=0, adc=4095, kp=16 -> sum=-3583, duty=0, sat_lo=1. Negative non-exact: err=-1, kp=1 -> scaled=-1, duty=511.
4. Throughput/flush: adc_valid on 5 consecutive cycles with distinct samples -> 5 consecutive duty_valid, correct order and values. Repeat with enable dropped after the 2nd sample -> no duty_valid for later samples, duty=0, pwm_out low next cycle.
5. PWM: duty=256 held -> pwm_out high 256 of every 1024 cycles, starting at counter 0. Duty changed to 768 at counter=300 -> current period unchanged, next period high 768 cycles.
6. Async reset asserted mid-pipeline and mid-PWM period -> all outputs 0 immediately. After release, no duty_valid until a new adc_valid.

Source files
------------

// File: rtl/maglev_pkg.sv
// Shared widths and datapath types for the maglev proportional position loop.
package maglev_pkg;

    localparam int unsigned ADC_W   = 12;
    localparam int unsigned KP_W    = 10;
    localparam int unsigned KP_FRAC = 4;
    localparam int unsigned PWM_W   = 10;
    localparam int          BIAS    = 512;

    localparam int unsigned PROD_W   = ADC_W + KP_W + 2;
    localparam int          DUTY_MAX = (2 ** PWM_W) - 1;

    typedef logic signed [ADC_W:0]    err_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [PROD_W:0]   sum_t;
    typedef logic [PWM_W-1:0]         duty_t;

endpackage

// File: rtl/maglev_pwm_gen.sv
// Free-running PWM generator; the active duty is reloaded only at the period boundary.
module maglev_pwm_gen
    import maglev_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  enable_i,
    input  duty_t duty_i,
    output logic  pwm_o
);

    duty_t cnt_q;
    duty_t active_q;
    logic  pwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            // Loading on the last count makes the new duty take effect exactly at count 0.
            if (cnt_q == '1) begin
                active_q <= duty_i;
            end
            pwm_q <= (cnt_q < active_q) & enable_i;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/maglev_p_ctrl.sv
// Proportional levitation controller: 3-stage err/product/saturate pipeline feeding the PWM.
module maglev_p_ctrl
    import maglev_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [KP_W-1:0]  kp,
    input  logic [ADC_W-1:0] setpoint,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [PWM_W-1:0] duty,
    output logic             duty_valid,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             pwm_out
);

    logic            v1_q;
    err_t            err_q;
    logic [KP_W-1:0] kp_q;
    logic            v2_q;
    prod_t           prod_q;
    duty_t           duty_q, duty_d;
    logic            dv_q, dv_d;
    logic            sat_hi_q, sat_hi_d;
    logic            sat_lo_q, sat_lo_d;
    prod_t           scaled;
    sum_t            sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q     <= 1'b0;
            err_q    <= '0;
            kp_q     <= '0;
            v2_q     <= 1'b0;
            prod_q   <= '0;
            duty_q   <= '0;
            dv_q     <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            v1_q <= adc_valid & enable;
            if (adc_valid & enable) begin
                err_q <= err_t'({1'b0, setpoint}) - err_t'({1'b0, adc_data});
                kp_q  <= kp;
            end
            v2_q     <= v1_q & enable;
            prod_q   <= prod_t'(err_q) * prod_t'($signed({1'b0, kp_q}));
            duty_q   <= duty_d;
            dv_q     <= dv_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
        end
    end

    always_comb begin
        scaled   = prod_q >>> KP_FRAC;
        sum      = sum_t'(scaled) + sum_t'(BIAS);
        duty_d   = duty_q;
        dv_d     = 1'b0;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        if (!enable) begin
            duty_d   = '0;
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
        end else if (v2_q) begin
            dv_d     = 1'b1;
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
            if (sum[PROD_W]) begin
                duty_d   = '0;
                sat_lo_d = 1'b1;
            end else if (sum > sum_t'(DUTY_MAX)) begin
                duty_d   = '1;
                sat_hi_d = 1'b1;
            end else begin
                duty_d = sum[PWM_W-1:0];
            end
        end
    end

    assign duty       = duty_q;
    assign duty_valid = dv_q;
    assign sat_hi     = sat_hi_q;
    assign sat_lo     = sat_lo_q;

    maglev_pwm_gen u_pwm (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (enable),
        .duty_i   (duty_q),
        .pwm_o    (pwm_out)
    );

endmodule
